// File: rtl/bch_p32_t8_pkg.sv
// Shared constants, state encoding and beat helpers for the BCH error corrector.
// Sigma k of a beat lives in bits [k*GF_M-1:(k-1)*GF_M] of the flat Chien bus.
package bch_p32_t8_pkg;

    localparam int GF_M   = 13;
    localparam int BCH_T  = 8;
    localparam int BCH_P  = 8;
    localparam int POP_W  = $clog2(BCH_P + 1);
    localparam int CNT_W  = 5;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } bch_state_t;

    // Element k holds sigma(k+1), i.e. the evaluation for data bit k.
    typedef logic [BCH_P-1:0][GF_M-1:0] sigma_beat_t;

    function automatic sigma_beat_t unpack_sigma(input logic [BCH_P*GF_M-1:0] flat);
        sigma_beat_t s;
        for (int k = 0; k < BCH_P; k++) begin
            s[k] = flat[k*GF_M +: GF_M];
        end
        return s;
    endfunction

    function automatic logic [POP_W-1:0] popcount_p(input logic [BCH_P-1:0] v);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < BCH_P; i++) begin
            c = c + POP_W'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/bch_align_fifo.sv
// Small synchronous FIFO that lets received data run ahead of its sigma beat.
// A push while full is accepted only when a pop frees the slot on the same edge.
module bch_align_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_push;
    logic         w_do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/bch_error_corrector_p8_t8.sv
// Final BCH correction stage: flips data bits whose Chien evaluation is zero,
// counts corrections per codeword and flags codewords it cannot trust.
module bch_error_corrector_p8_t8
    import bch_p32_t8_pkg::*;
#(
    parameter int M          = GF_M,
    parameter int P          = BCH_P,
    parameter int T          = BCH_T,
    parameter int N_BEATS    = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [3:0]     deg_lambda,
    input  logic [P-1:0]   data_in,
    input  logic           data_valid,
    output logic           data_ready,
    input  logic [P*M-1:0] sigma_in,
    input  logic           sigma_valid,
    output logic [P-1:0]   data_out,
    output logic [P-1:0]   err_mask,
    output logic           out_valid,
    output logic           done,
    output logic [4:0]     err_count,
    output logic           uncorrectable,
    output logic           align_err,
    output bch_state_t     dbg_state
);

    localparam int BW = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    // Handshakes: data_in is taken on any edge with data_valid && data_ready
    // (plus the full-and-popping case); sigma_valid has no ready and a beat is
    // consumed only in RUN when a data beat is already buffered.

    bch_state_t       r_state;
    logic [3:0]       r_deg;
    logic [BW-1:0]    r_beat_cnt;
    logic [P-1:0]     r_data_out;
    logic [P-1:0]     r_err_mask;
    logic             r_out_valid;
    logic             r_done;
    logic [CNT_W-1:0] r_err_count;
    logic             r_uncorr;
    logic             r_align_err;

    logic [P-1:0]     w_head;
    logic             w_full;
    logic             w_empty;
    logic             w_consume;
    logic             w_underrun;
    logic             w_overflow;
    sigma_beat_t      w_sigma;
    logic [P-1:0]     w_mask;
    logic [POP_W-1:0] w_pop;
    logic [CNT_W:0]   w_cnt_sum;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_last;

    assign w_consume  = (r_state == ST_RUN) && sigma_valid && !w_empty;
    assign w_underrun = (r_state == ST_RUN) && sigma_valid && w_empty;
    assign w_overflow = data_valid && w_full && !w_consume;

    bch_align_fifo #(
        .W     (P),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (data_valid),
        .i_din   (data_in),
        .i_pop   (w_consume),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_comb begin
        w_sigma = unpack_sigma(sigma_in);
        w_mask  = '0;
        for (int i = 0; i < P; i++) begin
            w_mask[i] = (w_sigma[i] == '0);
        end
    end

    assign w_pop      = popcount_p(w_mask);
    assign w_cnt_sum  = {1'b0, r_err_count} + {{(CNT_W + 1 - POP_W){1'b0}}, w_pop};
    assign w_cnt_next = (w_cnt_sum > (CNT_W + 1)'(31)) ? CNT_W'(31) : w_cnt_sum[CNT_W-1:0];
    assign w_last     = (r_beat_cnt == BW'(N_BEATS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_deg       <= '0;
            r_beat_cnt  <= '0;
            r_data_out  <= '0;
            r_err_mask  <= '0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_err_count <= '0;
            r_uncorr    <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            if (w_underrun || w_overflow) begin
                r_align_err <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state     <= ST_RUN;
                        r_deg       <= deg_lambda;
                        r_beat_cnt  <= '0;
                        r_err_count <= '0;
                        r_uncorr    <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (w_consume) begin
                        r_data_out  <= w_head ^ w_mask;
                        r_err_mask  <= w_mask;
                        r_out_valid <= 1'b1;
                        r_err_count <= w_cnt_next;
                        if (w_last) begin
                            // Verdict uses the count including this final beat.
                            r_done     <= 1'b1;
                            r_uncorr   <= (w_cnt_next != {1'b0, r_deg}) ||
                                          (w_cnt_next > CNT_W'(T));
                            r_state    <= ST_IDLE;
                            r_beat_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign data_ready    = !w_full;
    assign data_out      = r_data_out;
    assign err_mask      = r_err_mask;
    assign out_valid     = r_out_valid;
    assign done          = r_done;
    assign err_count     = r_err_count;
    assign uncorrectable = r_uncorr;
    assign align_err     = r_align_err;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_bch_error_corrector_p8_t8.sv
// Scoreboard bench for the BCH error corrector with a 4-beat codeword.
module tb_bch_error_corrector_p8_t8;

    localparam int M  = 13;
    localparam int P  = 8;
    localparam int NB = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [3:0]     deg_lambda;
    logic [P-1:0]   data_in;
    logic           data_valid;
    logic           data_ready;
    logic [P*M-1:0] sigma_in;
    logic           sigma_valid;
    logic [P-1:0]   data_out;
    logic [P-1:0]   err_mask;
    logic           out_valid;
    logic           done;
    logic [4:0]     err_count;
    logic           uncorrectable;
    logic           align_err;
    logic           dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;
    int cyc      = 0;

    logic [16:0] exp_q[$];
    int          cyc_q[$];

    bch_error_corrector_p8_t8 #(
        .N_BEATS    (NB),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .deg_lambda    (deg_lambda),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .sigma_in      (sigma_in),
        .sigma_valid   (sigma_valid),
        .data_out      (data_out),
        .err_mask      (err_mask),
        .out_valid     (out_valid),
        .done          (done),
        .err_count     (err_count),
        .uncorrectable (uncorrectable),
        .align_err     (align_err),
        .dbg_state     (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start       = 1'b0;
        deg_lambda  = '0;
        data_in     = '0;
        data_valid  = 1'b0;
        sigma_in    = '0;
        sigma_valid = 1'b0;
        reset       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [P*M-1:0] make_sigma(input logic [P-1:0] z);
        logic [P*M-1:0] s;
        for (int k = 0; k < P; k++) begin
            s[k*M +: M] = z[k] ? 13'd0 : 13'($urandom_range(1, 8191));
        end
        return s;
    endfunction

    task automatic exp_push(input logic [7:0] d, input logic [7:0] z, input logic last);
        exp_q.push_back({last, d ^ z, z});
        cyc_q.push_back(cyc + 1);
    endtask

    task automatic wait_done(input int base);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            if (n_done != base) break;
        end
        check("done_seen", 32'(n_done - base), 32'd1);
    endtask

    task automatic run_word(input logic with_start, input logic [3:0] deg,
                            input logic [31:0] dw, input logic [31:0] zw);
        int       base;
        int       ones;
        logic [4:0] exp_cnt;
        if (with_start) begin
            start      = 1'b1;
            deg_lambda = deg;
            step();
            start = 1'b0;
        end
        base = n_done;
        for (int b = 0; b <= NB; b++) begin
            data_valid  = (b < NB);
            if (b < NB) data_in = dw[8*b +: 8];
            sigma_valid = (b > 0);
            if (b > 0) begin
                sigma_in = make_sigma(zw[8*(b-1) +: 8]);
                exp_push(dw[8*(b-1) +: 8], zw[8*(b-1) +: 8], b == NB);
            end
            step();
        end
        data_valid  = 1'b0;
        sigma_valid = 1'b0;
        wait_done(base);
        ones    = $countones(zw);
        exp_cnt = (ones > 31) ? 5'd31 : 5'(ones);
        check("err_count", 32'(err_count), 32'(exp_cnt));
        check("uncorrectable", 32'(uncorrectable),
              32'(((exp_cnt != {1'b0, deg}) || (exp_cnt > 5'd8)) ? 1 : 0));
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [16:0] e;
        int          ec;
        if (reset) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(exp_q.size()), 32'd1);
                end else begin
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    check("data_out", 32'(data_out), 32'(e[15:8]));
                    check("err_mask", 32'(err_mask), 32'(e[7:0]));
                    check("done", 32'(done), 32'(e[16]));
                    check("latency", 32'(cyc), 32'(ec));
                end
            end else if (done) begin
                check("done_strobe", 32'(done), 32'd0);
            end
            if (done) n_done++;
        end
    end

    initial begin
        logic [31:0] dw;
        logic [31:0] zw;
        int          ones;

        apply_reset();
        reset = 1'b0;
        #1;
        check("rst_data_ready", 32'(data_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_uncorr", 32'(uncorrectable), 32'd0);
        check("rst_align_err", 32'(align_err), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_err_mask", 32'(err_mask), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // clean word, then corrected errors, then degree mismatches and saturation
        run_word(1'b1, 4'd0, 32'hA5A5A5A5, 32'h00000000);
        run_word(1'b1, 4'd3, 32'h5AFF3C00, 32'h00080081);
        run_word(1'b1, 4'd4, 32'h5AFF3C00, 32'h00080081);
        run_word(1'b1, 4'd8, 32'h12345678, 32'h000001FF);
        run_word(1'b1, 4'd15, 32'hDEADBEEF, 32'hFFFFFFFF);

        for (int w = 0; w < 4; w++) begin
            dw = $urandom;
            zw = '0;
            for (int b = 0; b < NB; b++) begin
                if ($urandom_range(0, 2) != 0) zw[8*b + $urandom_range(0, 7)] = 1'b1;
            end
            ones = $countones(zw);
            run_word(1'b1, 4'(ones + (w == 3 ? 1 : 0)), dw, zw);
        end

        // underrun: sigma with empty FIFO must not advance the beat count
        start      = 1'b1;
        deg_lambda = 4'd1;
        step();
        start       = 1'b0;
        sigma_valid = 1'b1;
        sigma_in    = make_sigma(8'h00);
        step();
        sigma_valid = 1'b0;
        check("underrun_align_err", 32'(align_err), 32'd1);
        check("underrun_state", 32'(dbg_state), 32'd1);
        run_word(1'b0, 4'd1, 32'h0F1E2D3C, 32'h00000400);
        check("align_err_sticky", 32'(align_err), 32'd1);

        apply_reset();
        check("align_err_cleared", 32'(align_err), 32'd0);

        // pre-buffered data, back-to-back sigma, ignored start in RUN
        for (int b = 0; b < 3; b++) begin
            data_valid = 1'b1;
            data_in    = 8'(8'h11 * (b + 1));
            step();
        end
        data_valid = 1'b0;
        check("prebuf_state", 32'(dbg_state), 32'd0);
        start      = 1'b1;
        deg_lambda = 4'd2;
        step();
        start = 1'b0;
        zw    = 32'h00020001;
        for (int b = 0; b < 3; b++) begin
            sigma_valid = 1'b1;
            sigma_in    = make_sigma(zw[8*b +: 8]);
            exp_push(8'(8'h11 * (b + 1)), zw[8*b +: 8], 1'b0);
            step();
        end
        sigma_valid = 1'b0;
        start       = 1'b1;
        deg_lambda  = 4'd7;
        data_valid  = 1'b1;
        data_in     = 8'h44;
        step();
        start      = 1'b0;
        data_valid = 1'b0;
        check("run_start_err_count", 32'(err_count), 32'd2);
        check("run_start_state", 32'(dbg_state), 32'd1);
        ones        = n_done;
        sigma_valid = 1'b1;
        sigma_in    = make_sigma(8'h00);
        exp_push(8'h44, 8'h00, 1'b1);
        step();
        sigma_valid = 1'b0;
        wait_done(ones);
        check("prebuf_err_count", 32'(err_count), 32'd2);
        check("prebuf_uncorr", 32'(uncorrectable), 32'd0);

        // overflow: fifth write with no pops
        for (int b = 0; b < 4; b++) begin
            data_valid = 1'b1;
            data_in    = 8'($urandom);
            step();
        end
        data_valid = 1'b0;
        check("full_data_ready", 32'(data_ready), 32'd0);
        check("full_no_align_err", 32'(align_err), 32'd0);
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        check("overflow_align_err", 32'(align_err), 32'd1);
        apply_reset();
        check("flush_data_ready", 32'(data_ready), 32'd1);

        // asynchronous reset in the middle of a codeword
        start      = 1'b1;
        deg_lambda = 4'd2;
        step();
        start      = 1'b0;
        data_valid = 1'b1;
        data_in    = 8'h3C;
        step();
        data_in     = 8'hC3;
        sigma_valid = 1'b1;
        sigma_in    = make_sigma(8'h03);
        exp_push(8'h3C, 8'h03, 1'b0);
        step();
        data_in  = 8'h77;
        sigma_in = make_sigma(8'h00);
        exp_push(8'hC3, 8'h00, 1'b0);
        step();
        data_valid  = 1'b0;
        sigma_valid = 1'b0;
        @(negedge clk);
        #2;
        check("pre_reset_err_count", 32'(err_count), 32'd2);
        reset = 1'b0;
        #1;
        check("async_data_out", 32'(data_out), 32'd0);
        check("async_err_mask", 32'(err_mask), 32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_err_count", 32'(err_count), 32'd0);
        check("async_state", 32'(dbg_state), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_word(1'b1, 4'd1, 32'h89ABCDEF, 32'h10000000);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
